// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver for 48-bit short responses (R1/R6/R7).
// Waits for the start bit, shifts the frame in MSB first, checks framing and
// CRC7, then posts the index and argument with a one-cycle oDone pulse.
// Optional build macro: SD_RX_CRC_EN. When it is defined, CRC7 is computed and
// compared. When it is undefined, the CRC bits are discarded and oCrc_ok reads 1
// on every posted result.
module sd_cmd_response_rx #(
  parameter int unsigned RESP_BITS      = 48,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        iSD_clock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iStart,
  input  logic        iSerial,
  output logic [5:0]  oIndex,
  output logic [31:0] oArgument,
  output logic        oCrc_ok,
  output logic        oFrame_err,
  output logic        oTimeout,
  output logic        oBusy,
  output logic        oDone
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitStart = 2'd1;
  localparam logic [1:0] StReceive   = 2'd2;
  localparam logic [1:0] StCheck     = 2'd3;

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] LastBit = 6'(RESP_BITS - 1);
  // Frame bits 1..40 are covered by the CRC.
  localparam logic [5:0] CrcBits = 6'd40;

  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  // Holds frame bits 2..48; after the end bit, [46] is the transmission bit
  // and [0] is the end bit, so the indices match the frame numbering.
  logic [46:0]     shreg_q, shreg_d;
  logic [5:0]      index_q, index_d;
  logic [31:0]     arg_q, arg_d;
  logic            crc_ok_q, crc_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;

`ifdef SD_RX_CRC_EN
  logic [6:0]      crc_q, crc_d;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction
`else
  // Received CRC bits are shifted in but never examined in this build.
  logic unused_crc_bits;
  assign unused_crc_bits = ^shreg_q[7:1];
`endif

  // Next-state logic: everything holds while iEnable is low; oDone is a one-cycle pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    shreg_d     = shreg_q;
    index_d     = index_q;
    arg_d       = arg_q;
    crc_ok_d    = crc_ok_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
`ifdef SD_RX_CRC_EN
    crc_d       = crc_q;
`endif
    if (iEnable) begin
      case (state_q)
        StIdle: begin
          if (iStart) begin
            state_d     = StWaitStart;
            crc_ok_d    = 1'b0;
            frame_err_d = 1'b0;
            timeout_d   = 1'b0;
            tmo_d       = '0;
            cnt_d       = '0;
`ifdef SD_RX_CRC_EN
            crc_d       = '0;
`endif
          end
        end
        StWaitStart: begin
          if (!iSerial) begin
            state_d = StReceive;
            cnt_d   = 6'd1;
`ifdef SD_RX_CRC_EN
            crc_d   = crc7_next(crc_q, 1'b0);
`endif
          end else if (tmo_q == TmoLast) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StReceive: begin
          shreg_d = {shreg_q[45:0], iSerial};
          cnt_d   = cnt_q + 6'd1;
`ifdef SD_RX_CRC_EN
          if (cnt_q < CrcBits) begin
            crc_d = crc7_next(crc_q, iSerial);
          end
`endif
          if (cnt_q == LastBit) begin
            state_d = StCheck;
          end
        end
        default: begin
          index_d     = shreg_q[45:40];
          arg_d       = shreg_q[39:8];
`ifdef SD_RX_CRC_EN
          crc_ok_d    = (shreg_q[7:1] == crc_q);
`else
          crc_ok_d    = 1'b1;
`endif
          frame_err_d = shreg_q[46] | ~shreg_q[0];
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge iSD_clock or negedge iReset) begin
    if (!iReset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shreg_q     <= '0;
      index_q     <= '0;
      arg_q       <= '0;
      crc_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef SD_RX_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shreg_q     <= shreg_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      crc_ok_q    <= crc_ok_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
`ifdef SD_RX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign oIndex     = index_q;
  assign oArgument  = arg_q;
  assign oCrc_ok    = crc_ok_q;
  assign oFrame_err = frame_err_q;
  assign oTimeout   = timeout_q;
  assign oDone      = done_q;
  assign oBusy      = (state_q != StIdle);

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Directed testbench for sd_cmd_response_rx. Inputs change on the falling edge
// and outputs are sampled on the falling edge, away from the rising edge.
module tb_sd_cmd_response_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        ser;
  logic [5:0]  o_index;
  logic [31:0] o_arg;
  logic        o_crc_ok;
  logic        o_frame_err;
  logic        o_timeout;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SD_RX_CRC_EN
  localparam logic CrcEn = 1'b1;
`else
  localparam logic CrcEn = 1'b0;
`endif

  always #5 clk = ~clk;

  sd_cmd_response_rx dut (
    .iSD_clock (clk),
    .iReset    (rst_n),
    .iEnable   (en),
    .iStart    (start),
    .iSerial   (ser),
    .oIndex    (o_index),
    .oArgument (o_arg),
    .oCrc_ok   (o_crc_ok),
    .oFrame_err(o_frame_err),
    .oTimeout  (o_timeout),
    .oBusy     (o_busy),
    .oDone     (o_done)
  );

  // Reference CRC7 (x^7 + x^3 + 1, initial 0) over the first 40 frame bits.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic trans, input logic [5:0] idx,
                                             input logic [31:0] arg);
    logic [39:0] head;
    head = {1'b0, trans, idx, arg};
    return {head, crc7(head), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Arm the receiver, then leave the line idle for 'idle' enabled cycles.
  task automatic arm(input int idle);
    start = 1'b1;
    en    = 1'b1;
    ser   = 1'b1;
    tick();
    start = 1'b0;
    repeat (idle) tick();
  endtask

  // Drive a 48-bit frame MSB first. Ticks are numbered from 1 at the start bit.
  // Optional stall (iEnable low) before bit index stall_at and an iStart pulse
  // at bit index pulse_at. Reports the tick at which oDone was first seen.
  task automatic run_frame(input logic [47:0] f, input int stall_at, input int stall_len,
                           input int pulse_at, output int done_tick, output int pulses);
    int t;
    t         = 0;
    done_tick = 0;
    pulses    = 0;
    for (int b = 0; b < 48; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          en  = 1'b0;
          ser = ~ser;
          t++;
          tick();
          if (o_done) begin
            pulses++;
            if (done_tick == 0) done_tick = t;
          end
        end
      end
      en    = 1'b1;
      ser   = f[47-b];
      start = (b == pulse_at);
      t++;
      tick();
      start = 1'b0;
      if (o_done) begin
        pulses++;
        if (done_tick == 0) done_tick = t;
      end
    end
    en  = 1'b1;
    ser = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t++;
      tick();
      if (o_done) begin
        pulses++;
        if (done_tick == 0) done_tick = t;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    start = 1'b0;
    ser   = 1'b1;
    #1;
    n_checks++;
    if ({o_index, o_arg, o_crc_ok, o_frame_err, o_timeout, o_busy, o_done} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got idx=%0d arg=%h crc=%b fe=%b to=%b busy=%b done=%b, required all 0",
               o_index, o_arg, o_crc_ok, o_frame_err, o_timeout, o_busy, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b, required 0", o_busy);
    end
  endtask

  task automatic test_r1();
    int dt, np;
    arm(5);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL r1_busy_wait: got %b, required 1", o_busy);
    end
    run_frame(make_frame(1'b0, 6'd17, 32'h0000_0900), -1, 0, -1, dt, np);
    n_checks++;
    if (dt !== 49) begin
      n_fail++;
      $display("FAIL r1_done_latency: got tick %0d, required 49", dt);
    end
    n_checks++;
    if (np !== 1) begin
      n_fail++;
      $display("FAIL r1_done_pulses: got %0d, required 1", np);
    end
    n_checks++;
    if (o_index !== 6'd17) begin
      n_fail++;
      $display("FAIL r1_index: got %0d, required 17", o_index);
    end
    n_checks++;
    if (o_arg !== 32'h0000_0900) begin
      n_fail++;
      $display("FAIL r1_argument: got %h, required 00000900", o_arg);
    end
    n_checks++;
    if ({o_crc_ok, o_frame_err, o_timeout} !== 3'b100) begin
      n_fail++;
      $display("FAIL r1_flags: got crc=%b fe=%b to=%b, required 1 0 0",
               o_crc_ok, o_frame_err, o_timeout);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_busy_after: got %b, required 0", o_busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [47:0] f;
    int dt, np;
    f = make_frame(1'b0, 6'd42, 32'hDEAD_BEEF);
    arm(2);
    for (int b = 0; b < 20; b++) begin
      ser = f[47-b];
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_index, o_arg, o_crc_ok, o_frame_err, o_timeout, o_busy, o_done} !== 43'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got idx=%0d arg=%h crc=%b fe=%b to=%b busy=%b done=%b, required all 0",
               o_index, o_arg, o_crc_ok, o_frame_err, o_timeout, o_busy, o_done);
    end
    tick();
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %b, required 0", o_done);
    end
    rst_n = 1'b1;
    arm(0);
    run_frame(f, -1, 0, -1, dt, np);
    n_checks++;
    if (o_index !== 6'd42 || o_arg !== 32'hDEAD_BEEF || o_crc_ok !== 1'b1 || o_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_next_frame: got idx=%0d arg=%h crc=%b fe=%b, required 42 deadbeef 1 0",
               o_index, o_arg, o_crc_ok, o_frame_err);
    end
    n_checks++;
    if (dt !== 49 || np !== 1) begin
      n_fail++;
      $display("FAIL midreset_next_done: got tick %0d pulses %0d, required 49 1", dt, np);
    end
  endtask

  task automatic test_cmd0();
    int dt, np;
    arm(1);
    run_frame(48'h40_0000_0000_95, -1, 0, -1, dt, np);
    n_checks++;
    if ({o_crc_ok, o_frame_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL cmd0_flags: got crc=%b fe=%b, required 1 1", o_crc_ok, o_frame_err);
    end
    n_checks++;
    if (o_index !== 6'd0 || o_arg !== 32'd0) begin
      n_fail++;
      $display("FAIL cmd0_fields: got idx=%0d arg=%h, required 0 00000000", o_index, o_arg);
    end
  endtask

  task automatic test_bad_crc();
    logic [47:0] f;
    int dt, np;
    // Frame bit 10 (1-based, MSB first) is argument bit 30.
    f = make_frame(1'b0, 6'd17, 32'h0000_0900) ^ (48'h1 << 38);
    arm(3);
    run_frame(f, -1, 0, -1, dt, np);
    n_checks++;
    if (o_crc_ok !== ~CrcEn) begin
      n_fail++;
      $display("FAIL badcrc_crc_ok: got %b, required %b", o_crc_ok, ~CrcEn);
    end
    n_checks++;
    if (o_frame_err !== 1'b0 || o_arg !== 32'h4000_0900 || o_index !== 6'd17) begin
      n_fail++;
      $display("FAIL badcrc_fields: got fe=%b arg=%h idx=%0d, required 0 40000900 17",
               o_frame_err, o_arg, o_index);
    end
  endtask

  task automatic test_timeout();
    int dt;
    arm(0);
    dt = 0;
    for (int t = 1; t <= 200 && dt == 0; t++) begin
      tick();
      if (o_done) dt = t;
    end
    n_checks++;
    if (dt !== 64) begin
      n_fail++;
      $display("FAIL timeout_tick: got %0d, required 64", dt);
    end
    n_checks++;
    if ({o_timeout, o_busy, o_crc_ok, o_frame_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL timeout_flags: got to=%b busy=%b crc=%b fe=%b, required 1 0 0 0",
               o_timeout, o_busy, o_crc_ok, o_frame_err);
    end
    n_checks++;
    if (o_index !== 6'd17 || o_arg !== 32'h4000_0900) begin
      n_fail++;
      $display("FAIL timeout_hold_fields: got idx=%0d arg=%h, required 17 40000900", o_index, o_arg);
    end
    tick();
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_single_pulse: got %b, required 0", o_done);
    end
  endtask

  task automatic test_timeout_gated();
    int dt;
    arm(0);
    dt = 0;
    // Enabled on odd ticks only, so the 64th enabled sample is tick 127.
    for (int t = 1; t <= 400 && dt == 0; t++) begin
      en = t[0];
      tick();
      if (o_done) dt = t;
    end
    en = 1'b1;
    n_checks++;
    if (dt !== 127) begin
      n_fail++;
      $display("FAIL gated_timeout_tick: got %0d, required 127", dt);
    end
    n_checks++;
    if (o_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL gated_timeout_flag: got %b, required 1", o_timeout);
    end
  endtask

  task automatic test_stall_and_start();
    int dt, np;
    arm(2);
    run_frame(make_frame(1'b0, 6'd3, 32'h1234_5678), 24, 3, 5, dt, np);
    n_checks++;
    if (dt !== 52 || np !== 1) begin
      n_fail++;
      $display("FAIL stall_done: got tick %0d pulses %0d, required 52 1", dt, np);
    end
    n_checks++;
    if (o_index !== 6'd3 || o_arg !== 32'h1234_5678 || o_crc_ok !== 1'b1 || o_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fields: got idx=%0d arg=%h crc=%b fe=%b, required 3 12345678 1 0",
               o_index, o_arg, o_crc_ok, o_frame_err);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_after: got busy=%b, required 0", o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_r1();
    test_mid_reset();
    test_cmd0();
    test_bad_crc();
    test_timeout();
    test_timeout_gated();
    test_stall_and_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
